// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART.
// Optional parity support is selected with the UART_PARITY_EN macro.
package uart_pkg;

  localparam int DATA_BITS_MIN    = 5;
  localparam int DATA_BITS_MAX    = 9;
  localparam int STOP_BITS_MAX    = 2;
  localparam int CLKS_PER_BIT_MIN = 4;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and occupancy level.
// Push when full and pop when empty are ignored; full/empty derive from level.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LEVEL_FULL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // storage write; contents need no reset because level gates visibility
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // pointers wrap naturally at the power-of-two depth; level tracks 0..DEPTH
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Buffered full-duplex UART: TX/RX FIFOs around a baud-timed framer and deframer.
// Macro UART_PARITY_EN inserts and checks a parity bit (PARITY_ODD selects sense).
//
// TX state   | meaning
// TX_IDLE    | line idle, pops FIFO when it holds a byte
// TX_START   | start bit (0)
// TX_DATA    | payload bits, LSB first
// TX_PARITY  | parity bit (macro builds only)
// TX_STOP    | stop bit(s); chains straight into TX_START if FIFO non-empty
//
// RX state     | meaning
// RX_IDLE      | waiting for a falling edge on the synchronised line
// RX_START     | half-bit wait, start re-sampled to reject glitches
// RX_DATA      | payload sampled at bit centres
// RX_PARITY    | parity sampled and checked (macro builds only)
// RX_STOP      | first stop bit sampled, byte pushed or error flagged
// RX_WAIT_HIGH | after a framing error, hold until the line returns high
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  input  logic                          rx,
  output logic                          tx
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT * STOP_BITS_MAX);
  localparam int IDX_W        = $clog2(DATA_BITS_MAX);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
  localparam bit PAR_ODD = (PARITY_ODD != 0);
`endif

  tx_state_e            tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [IDX_W-1:0]     tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_full, tx_empty, tx_pop, tx_tc, tx_line_busy;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  rx_state_e            rx_state;
  logic [CNT_W-1:0]     rx_cnt;
  logic [IDX_W-1:0]     rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_meta, rx_sync, rx_sync_d;
  logic                 rx_full, rx_empty, rx_push, rx_tc, rx_par_bad;

  // tx lags the FSM by one clock, so tx_line_busy stretches busy over the final stop clock
  assign tx_tc    = (tx_cnt == '0);
  assign tx_ready = !tx_full;
  assign tx_pop   = !tx_empty && ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_tc));
  assign tx_busy  = tx_line_busy || (tx_state != TX_IDLE) || !tx_empty;

  assign rx_tc    = (rx_cnt == '0);
  assign rx_valid = !rx_empty;
  assign rx_push  = (rx_state == RX_STOP) && rx_tc && rx_sync && !rx_par_bad;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock(clock), .reset(reset), .push(tx_valid), .push_data(tx_data), .pop(tx_pop),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock(clock), .reset(reset), .push(rx_push), .push_data(rx_shift), .pop(rx_ready),
    .head(rx_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  // TX framer: bit timing by down-counter, line driven one clock after the state it encodes
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state     <= TX_IDLE;
      tx_cnt       <= '0;
      tx_idx       <= '0;
      tx_shift     <= '0;
      tx_line_busy <= 1'b0;
      tx           <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par       <= 1'b0;
`endif
    end else begin
      tx_line_busy <= (tx_state != TX_IDLE);
      if (tx_pop) begin
        tx_shift <= tx_head;
`ifdef UART_PARITY_EN
        tx_par   <= (^tx_head) ^ PAR_ODD;
`endif
      end
      if (!tx_tc) tx_cnt <= tx_cnt - CNT_W'(1);
      case (tx_state)
        TX_IDLE: begin
          tx <= 1'b1;
          if (tx_pop) begin
            tx_state <= TX_START;
            tx_cnt   <= BIT_LAST;
          end
        end
        TX_START: begin
          tx <= 1'b0;
          if (tx_tc) begin
            tx_state <= TX_DATA;
            tx_cnt   <= BIT_LAST;
            tx_idx   <= '0;
          end
        end
        TX_DATA: begin
          tx <= tx_shift[0];
          if (tx_tc) begin
            tx_shift <= tx_shift >> 1;
            if (tx_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
              tx_state <= TX_PARITY;
              tx_cnt   <= BIT_LAST;
`else
              tx_state <= TX_STOP;
              tx_cnt   <= STOP_LAST;
`endif
            end else begin
              tx_idx <= tx_idx + IDX_W'(1);
              tx_cnt <= BIT_LAST;
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          tx <= tx_par;
          if (tx_tc) begin
            tx_state <= TX_STOP;
            tx_cnt   <= STOP_LAST;
          end
        end
`endif
        TX_STOP: begin
          tx <= 1'b1;
          if (tx_tc) begin
            if (tx_pop) begin
              tx_state <= TX_START;
              tx_cnt   <= BIT_LAST;
            end else begin
              tx_state <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // two-flop synchroniser plus one more stage for falling-edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_sync_d <= 1'b1;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_sync_d <= rx_sync;
    end
  end

`ifndef UART_PARITY_EN
  assign rx_par_bad    = 1'b0;
  assign rx_parity_err = 1'b0;
`endif

  // RX deframer: half-bit start qualification, then centre sampling; error flags are 1-clock pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad    <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
`ifdef UART_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      if (!rx_tc) rx_cnt <= rx_cnt - CNT_W'(1);
      case (rx_state)
        RX_IDLE: begin
          if (rx_sync_d && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_tc) begin
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_cnt   <= BIT_LAST;
              rx_idx   <= '0;
            end
          end
        end
        RX_DATA: begin
          if (rx_tc) begin
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            rx_cnt   <= BIT_LAST;
            if (rx_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end else begin
              rx_idx <= rx_idx + IDX_W'(1);
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (rx_tc) begin
            rx_par_bad <= rx_sync ^ (^rx_shift) ^ PAR_ODD;
            rx_state   <= RX_STOP;
            rx_cnt     <= BIT_LAST;
          end
        end
`endif
        RX_STOP: begin
          if (rx_tc) begin
            if (!rx_sync) begin
              rx_frame_err <= 1'b1;
              rx_state     <= RX_WAIT_HIGH;
            end else begin
              rx_state <= RX_IDLE;
`ifdef UART_PARITY_EN
              if (rx_par_bad) rx_parity_err <= 1'b1;
              else if (rx_full) rx_overrun <= 1'b1;
`else
              if (rx_full) rx_overrun <= 1'b1;
`endif
            end
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: 50 clocks/bit, 4-deep FIFOs, tx looped to rx
// except where the bench drives the serial input itself.
module tb_uart_fifo_ctrl;

  localparam int CLKS = 50;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam bit PAR_EN     = 1'b1;
`else
  localparam int FRAME_BITS = 10;
  localparam bit PAR_EN     = 1'b0;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * CLKS;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       rx_frame_err, rx_parity_err, rx_overrun;
  logic [2:0] tx_level, rx_level;
  logic       rx_line, tx;
  logic       use_loop, rx_drv;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ferr   = 0;
  int n_perr   = 0;
  int n_ovr    = 0;

  logic [7:0] t2_bytes [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
  logic [7:0] t3_bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  assign rx_line = use_loop ? tx : rx_drv;

  uart_fifo_ctrl #(
    .CLOCK_FREQ(50_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
    .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)
  ) dut (
    .clock(clock), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun),
    .tx_level(tx_level), .rx_level(rx_level), .rx(rx_line), .tx(tx)
  );

  always #5 clock = ~clock;

  // error pulse monitors count clocks each flag is high
  always @(posedge clock) begin
    if (rx_frame_err === 1'b1)  n_ferr++;
    if (rx_parity_err === 1'b1) n_perr++;
    if (rx_overrun === 1'b1)    n_ovr++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic pop_byte();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic wait_tx_idle(input int budget, input string tag);
    int n = 0;
    while (tx_busy && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, tx_busy, 0);
  endtask

  task automatic drive_bit(input logic b);
    rx_drv = b;
    repeat (CLKS) tick();
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_val, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit((^d) ^ par_flip);
    drive_bit(stop_val);
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (PAR_EN && k == 9) return ^d;
    return 1'b1;
  endfunction

  initial begin
    int base_f, base_p, base_o;
    reset    = 1'b1;
    tx_data  = '0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    rx_drv   = 1'b1;
    use_loop = 1'b1;
    repeat (3) tick();
    check_val("rst_tx", tx, 1);
    check_val("rst_tx_busy", tx_busy, 0);
    check_val("rst_tx_ready", tx_ready, 1);
    check_val("rst_rx_valid", rx_valid, 0);
    check_val("rst_tx_level", tx_level, 0);
    check_val("rst_rx_level", rx_level, 0);
    check_val("rst_errs", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
    reset = 1'b0;
    tick();

    // single byte, exact frame timing on the line
    base_f = n_ferr; base_p = n_perr; base_o = n_ovr;
    push_byte(8'h55);
    tick();
    check_val("t1_tx_high_e1", tx, 1);
    tick();
    check_val("t1_tx_low_e2", tx, 0);
    check_val("t1_busy", tx_busy, 1);
    repeat (25) tick();
    for (int k = 0; k < FRAME_BITS; k++) begin
      if (k != 0) repeat (CLKS) tick();
      check_val($sformatf("t1_bit%0d", k), tx, frame_bit(8'h55, k));
    end
    repeat (24) tick();
    check_val("t1_busy_last_stop", tx_busy, 1);
    tick();
    check_val("t1_busy_drop", tx_busy, 0);
    check_val("t1_rx_valid", rx_valid, 1);
    check_val("t1_rx_data", rx_data, 8'h55);
    check_val("t1_no_errs", (n_ferr - base_f) + (n_perr - base_p) + (n_ovr - base_o), 0);
    pop_byte();
    check_val("t1_rx_level_after_pop", rx_level, 0);

    // back-to-back burst, zero gap between frames
    for (int i = 0; i < 4; i++) begin
      tx_data  = t2_bytes[i];
      tx_valid = 1'b1;
      check_val($sformatf("t2_ready%0d", i), tx_ready, 1);
      tick();
    end
    tx_valid = 1'b0;
    check_val("t2_tx_level", tx_level, 3);
    repeat (FRAME_CLKS - 2) tick();
    for (int k = 1; k < 4; k++) begin
      if (k > 1) repeat (FRAME_CLKS - 1) tick();
      check_val($sformatf("t2_stop_before_%0d", k), tx, 1);
      tick();
      check_val($sformatf("t2_start_%0d", k), tx, 0);
    end
    wait_tx_idle(FRAME_CLKS * 2, "t2_tx_idle_timeout");
    check_val("t2_rx_level", rx_level, 4);
    check_val("t2_no_overrun", n_ovr - base_o, 0);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("t2_rx_valid%0d", i), rx_valid, 1);
      check_val($sformatf("t2_rx_data%0d", i), rx_data, t2_bytes[i]);
      pop_byte();
    end
    check_val("t2_rx_empty", rx_valid, 0);

    // overfill both FIFOs without popping
    base_o = n_ovr;
    for (int i = 0; i < 6; i++) begin
      tx_data  = t3_bytes[i];
      tx_valid = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    check_val("t3_tx_level_full", tx_level, 4);
    check_val("t3_tx_ready_low", tx_ready, 0);
    wait_tx_idle(FRAME_CLKS * 6, "t3_tx_idle_timeout");
    repeat (5) tick();
    check_val("t3_overrun_once", n_ovr - base_o, 1);
    check_val("t3_rx_level", rx_level, 4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("t3_rx_data%0d", i), rx_data, t3_bytes[i]);
      pop_byte();
    end
    check_val("t3_rx_level_after", rx_level, 0);

    // framing error driven directly, then recovery with a clean frame
    use_loop = 1'b0;
    rx_drv   = 1'b1;
    repeat (10) tick();
    base_f = n_ferr;
    drive_frame(8'h12, 1'b0, 1'b0);
    rx_drv = 1'b1;
    repeat (2 * CLKS) tick();
    check_val("t4_frame_err_pulse", n_ferr - base_f, 1);
    check_val("t4_rx_level", rx_level, 0);
    drive_frame(8'h12, 1'b1, 1'b0);
    repeat (CLKS) tick();
    check_val("t4_recover_valid", rx_valid, 1);
    check_val("t4_recover_data", rx_data, 8'h12);
    pop_byte();

    // short low glitch must be ignored
    base_f = n_ferr; base_p = n_perr;
    rx_drv = 1'b0;
    repeat (10) tick();
    rx_drv = 1'b1;
    repeat (FRAME_CLKS + CLKS) tick();
    check_val("t5_glitch_valid", rx_valid, 0);
    check_val("t5_glitch_errs", (n_ferr - base_f) + (n_perr - base_p), 0);

`ifdef UART_PARITY_EN
    // parity bit on the line and a corrupted parity on input
    use_loop = 1'b1;
    push_byte(8'h07);
    repeat (2 + 25 + 9 * CLKS) tick();
    check_val("t6_parity_bit", tx, 1);
    wait_tx_idle(FRAME_CLKS, "t6_tx_idle_timeout");
    check_val("t6_rx_data", rx_data, 8'h07);
    pop_byte();
    use_loop = 1'b0;
    base_p = n_perr;
    drive_frame(8'h07, 1'b1, 1'b1);
    repeat (CLKS) tick();
    check_val("t6_parity_err", n_perr - base_p, 1);
    check_val("t6_rx_level", rx_level, 0);
`endif

    // reset in the middle of data bit 3
    use_loop = 1'b1;
    base_f = n_ferr;
    push_byte(8'hF0);
    repeat (220) tick();
    check_val("t7_tx_bit3", tx, 0);
    reset = 1'b1;
    tick();
    check_val("t7_tx_after_reset", tx, 1);
    check_val("t7_busy_after_reset", tx_busy, 0);
    check_val("t7_tx_level", tx_level, 0);
    check_val("t7_rx_level", rx_level, 0);
    reset = 1'b0;
    repeat (3) tick();
    push_byte(8'h81);
    wait_tx_idle(FRAME_CLKS + 10, "t7_tx_idle_timeout");
    check_val("t7_rx_valid", rx_valid, 1);
    check_val("t7_rx_data", rx_data, 8'h81);
    check_val("t7_no_frame_err", n_ferr - base_f, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
